alu_seq_md: RTL and testbench

//   Parametrised, registered execute-stage ALU with an iterative multiply/divide engine and HI/LO registers.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 107 ++++++++++
 rtl/alu_seq_md.sv | 147 ++++++++++++++
 tb/tb_alu_seq_md.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU (alu_seq_md).
package alu_pkg;

    // Single-cycle codes (zero-extended 4-bit legacy set)
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_LUI   = 5'b00101;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_SLTU  = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01001;
    localparam logic [4:0] OP_SRA   = 5'b01010;
    localparam logic [4:0] OP_MFHI  = 5'b01011;
    localparam logic [4:0] OP_MFLO  = 5'b01100;
    // Multi-cycle codes
    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative multiply/divide engine: loads magnitudes on start, runs one bit per step,
// and presents sign-corrected HI/LO. Divider datapath exists only with ALU_DIV_EN defined.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
`ifdef ALU_DIV_EN
    input  logic             div_i,
`endif
    input  logic             signed_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_a_q, neg_b_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef ALU_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     div_shift, div_diff;
`endif

    assign a_mag  = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign b_mag  = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
    assign last_o = (cnt_q == CNT_W'(WIDTH-1));
    assign prod   = {acc_q, q_q};

    // acc/q/m double as partial-product/multiplier/multiplicand and remainder/quotient/divisor
    always_comb begin
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
`ifdef ALU_DIV_EN
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
`endif
        if (start_i) begin
            acc_d = '0;
            q_d   = a_mag;
            m_d   = b_mag;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_DIV_EN
            if (div_q) begin
                acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else
`endif
            begin
                acc_d = mul_sum[WIDTH:1];
                q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
`ifdef ALU_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            if (start_i) begin
                neg_a_q <= signed_i & a_i[WIDTH-1];
                neg_b_q <= signed_i & b_i[WIDTH-1];
`ifdef ALU_DIV_EN
                div_q   <= div_i;
`endif
            end
        end
    end

    // Quotient takes the product sign; remainder follows the dividend
    always_comb begin
        {hi_o, lo_o} = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
`ifdef ALU_DIV_EN
        if (div_q) begin
            lo_o = (neg_a_q ^ neg_b_q) ? (~q_q + 1'b1) : q_q;
            hi_o = neg_a_q ? (~acc_q + 1'b1) : acc_q;
        end
`endif
    end

endmodule

// File: rtl/alu_seq_md.sv
// Registered EX-stage ALU with iterative mul/div and HI/LO; divide support is built only
// when ALU_DIV_EN is defined.
module alu_seq_md
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   res,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output alu_state_e         dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // out_valid/res stay put until out_ready is seen with out_valid.
    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d, alu_res;
    logic             out_valid_q, out_valid_d;
    logic             accept, op_mul, op_div, op_signed;
    logic             eng_last;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    assign in_ready    = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
    assign accept      = in_valid & in_ready;
    assign op_mul      = (alu_ctrl == OP_MULT) | (alu_ctrl == OP_MULTU);
    assign op_signed   = (alu_ctrl == OP_MULT) | (alu_ctrl == OP_DIV);
`ifdef ALU_DIV_EN
    assign op_div      = (alu_ctrl == OP_DIV) | (alu_ctrl == OP_DIVU);
`else
    assign op_div      = 1'b0;
`endif
    assign out_valid   = out_valid_q;
    assign res         = res_q;
    assign zero        = (res_q == '0);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX);
    assign dbg_state_o = state_q;

    // Shifts act on rt (data2), as in MIPS; oversized counts fall out of the shift operators
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_ADD:  alu_res = data1 + data2;
            OP_SUB:  alu_res = data1 - data2;
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_XOR:  alu_res = data1 ^ data2;
            OP_LUI:  alu_res = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            OP_SLL:  alu_res = data2 << shamt;
            OP_SRL:  alu_res = data2 >> shamt;
            OP_SRA:  alu_res = $signed(data2) >>> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_mul) begin
                        state_d = ST_MUL;
`ifdef ALU_DIV_EN
                    end else if (op_div && (data2 == '0)) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        res_d       = '1;
                        lo_d        = '1;
                        hi_d        = data1;
                    end else if (op_div) begin
                        state_d = ST_DIV;
`endif
                    end else begin
                        res_d       = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: if (eng_last) state_d = ST_FIX;
            ST_FIX: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                res_d       = eng_lo;
                hi_d        = eng_hi;
                lo_d        = eng_lo;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            res_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept & (op_mul | op_div)),
`ifdef ALU_DIV_EN
        .div_i    (op_div),
`endif
        .signed_i (op_signed),
        .step_i   ((state_q == ST_MUL) | (state_q == ST_DIV)),
        .a_i      (data1),
        .b_i      (data2),
        .last_o   (eng_last),
        .hi_o     (eng_hi),
        .lo_o     (eng_lo)
    );

endmodule

// File: tb/tb_alu_seq_md.sv
// Bench for alu_seq_md: directed vector table, hand sequences for stall/reset, random vs model.
module tb_alu_seq_md;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, out_ready;
    logic [4:0]    alu_ctrl;
    logic [W-1:0]  data1, data2;
    logic [SW-1:0] shamt;
    logic          in_ready, out_valid, zero, busy;
    logic [W-1:0]  res, hi, lo;
    alu_state_e    dbg_state;

    alu_seq_md #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .data1(data1), .data2(data2), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .zero(zero),
        .hi(hi), .lo(lo), .busy(busy), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct {
        logic [4:0]    op;
        logic [W-1:0]  a, b;
        logic [SW-1:0] sh;
        logic [W-1:0]  r, h, l;
        int            lat;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [W-1:0] a, b, input logic [SW-1:0] sh,
                           input logic [W-1:0] r, h, l, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.r = r; v.h = h; v.l = l; v.lat = lat;
        tbl.push_back(v);
    endtask

    // Reference: architectural meaning of each op in plain 64-bit arithmetic
    function automatic logic [W-1:0] ref_op(input logic [4:0] op, input logic [W-1:0] a, b,
                                            input logic [SW-1:0] sh);
        longint     sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_LUI:   return {b[15:0], 16'h0};
            OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:   return (sh >= 32) ? 32'd0 : (b << sh);
            OP_SRL:   return (sh >= 32) ? 32'd0 : (b >> sh);
            OP_SRA:   return (sh >= 32) ? {32{b[31]}} : 32'(sb >>> sh);
            OP_MFHI:  return m_hi;
            OP_MFLO:  return m_lo;
            OP_MULT:  begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; return m_lo; end
            OP_MULTU: begin up = {32'h0, a} * {32'h0, b}; m_hi = up[63:32]; m_lo = up[31:0]; return m_lo; end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                return m_lo;
            end
            OP_DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
                return m_lo;
            end
`endif
            default:  return '0;
        endcase
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, b, input logic [SW-1:0] sh,
                          output logic [W-1:0] r, h, l, output logic z, output int lat,
                          output bit rdy_seen);
        int guard;
        @(negedge clk);
        alu_ctrl = op; data1 = a; data2 = b; shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; rdy_seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1;
            @(negedge clk);
            lat++;
        end
        r = res; h = hi; l = lo; z = zero;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    logic [4:0] op_list[16] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LUI, OP_SLT, OP_SLTU,
                                OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MULT, OP_DIV, 5'h0F};

    initial begin
        logic [W-1:0] r, h, l, e;
        logic z;
        int lat, cnt;
        bit rdy;

        // Clock/reset
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; data1 = '0; data2 = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst res", res, 0);
        check("rst zero", zero, 1);
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;

        // Back-to-back single-cycle ops, no bubble
        @(negedge clk);
        alu_ctrl = OP_ADD; data1 = 32'h7FFF_FFFF; data2 = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
        check("b2b ready0", in_ready, 1);
        @(negedge clk);
        check("b2b add valid", out_valid, 1);
        check("b2b add res", res, 32'h8000_0000);
        check("b2b add zero", zero, 0);
        check("b2b ready1", in_ready, 1);
        alu_ctrl = OP_SUB; data1 = 32'd5; data2 = 32'd5;
        @(negedge clk);
        check("b2b sub valid", out_valid, 1);
        check("b2b sub res", res, 0);
        check("b2b sub zero", zero, 1);
        in_valid = 1'b0;

        // Directed vector table
        add_vec(OP_ADD,  32'h7FFF_FFFF, 32'h1,         0,  32'h8000_0000, 0, 0, 1);
        add_vec(OP_SUB,  32'd5,         32'd5,         0,  32'h0,         0, 0, 1);
        add_vec(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 0,  32'hF000_F000, 0, 0, 1);
        add_vec(OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 0,  32'hFFF0_FFF0, 0, 0, 1);
        add_vec(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 0,  32'h0FF0_0FF0, 0, 0, 1);
        add_vec(OP_LUI,  32'h0,         32'hABCD_1234, 0,  32'h1234_0000, 0, 0, 1);
        add_vec(OP_SLT,  32'hFFFF_FFFF, 32'h1,         0,  32'h1,         0, 0, 1);
        add_vec(OP_SLTU, 32'hFFFF_FFFF, 32'h1,         0,  32'h0,         0, 0, 1);
        add_vec(OP_SRA,  32'h0,         32'h8000_0000, 31, 32'hFFFF_FFFF, 0, 0, 1);
        add_vec(OP_SLL,  32'h0,         32'h1,         32, 32'h0,         0, 0, 1);
        add_vec(OP_SRL,  32'h0,         32'h8000_0000, 4,  32'h0800_0000, 0, 0, 1);
        add_vec(OP_SRA,  32'h0,         32'h8000_0000, 40, 32'hFFFF_FFFF, 0, 0, 1);
        add_vec(OP_SLL,  32'h0,         32'h3,         4,  32'h30,        0, 0, 1);
        add_vec(5'h0F,   32'h1234,      32'h5678,      0,  32'h0,         0, 0, 1);
        add_vec(OP_MULT, 32'hFFFF_FFFD, 32'd7,         0,  32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        add_vec(OP_MFHI, 32'h0,         32'h0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
        add_vec(OP_MULTU,32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  32'h1,         32'hFFFF_FFFE, 32'h1, 34);
        add_vec(OP_MFLO, 32'h0,         32'h0,         0,  32'h1,         32'hFFFF_FFFE, 32'h1, 1);
`ifdef ALU_DIV_EN
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,         0,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        add_vec(OP_DIV,  32'd7,         32'hFFFF_FFFE, 0,  32'hFFFF_FFFD, 32'h1,         32'hFFFF_FFFD, 34);
        add_vec(OP_DIV,  32'h1234,      32'h0,         0,  32'hFFFF_FFFF, 32'h1234,      32'hFFFF_FFFF, 1);
        add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0,  32'h8000_0000, 32'h0,         32'h8000_0000, 34);
        add_vec(OP_DIVU, 32'hFFFF_FFFF, 32'd10,        0,  32'h1999_9999, 32'h5,         32'h1999_9999, 34);
`else
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,         0,  32'h0,         32'hFFFF_FFFE, 32'h1, 1);
        add_vec(OP_DIVU, 32'd10,        32'd3,         0,  32'h0,         32'hFFFF_FFFE, 32'h1, 1);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, r, h, l, z, lat, rdy);
            check($sformatf("vec%0d res", i), r, tbl[i].r);
            check($sformatf("vec%0d zero", i), z, (tbl[i].r == 0));
            check($sformatf("vec%0d hi", i), h, tbl[i].h);
            check($sformatf("vec%0d lo", i), l, tbl[i].l);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
            if (tbl[i].lat > 1) check($sformatf("vec%0d ready low", i), rdy, 0);
        end

        // Result held in DONE while consumer stalls
        @(negedge clk);
        alu_ctrl = OP_MULT; data1 = 32'd2; data2 = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
        cnt = 0;
        while (!in_ready && cnt < 200) begin @(negedge clk); cnt++; end
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin @(negedge clk); cnt++; end
        for (int k = 0; k < 5; k++) begin
            check("hold res", res, 32'd6);
            check("hold valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        alu_ctrl = OP_ADD; data1 = 32'd1; data2 = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        check("release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("release add valid", out_valid, 1);
        check("release add res", res, 32'd2);
        check("release lo", lo, 32'd6);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        alu_ctrl = OP_MULT; data1 = 32'd5; data2 = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midop busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async busy", busy, 0);
        check("async hi", hi, 0);
        check("async lo", lo, 0);
        check("async out_valid", out_valid, 0);
        check("async in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        run_op(OP_MFHI, 32'h0, 32'h0, 0, r, h, l, z, lat, rdy);
        check("post-reset mfhi", r, 0);
        check("post-reset mfhi latency", 64'(lat), 1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [4:0]    op;
            logic [W-1:0]  a, b;
            logic [SW-1:0] sh;
            @(negedge clk);
            op = op_list[$urandom_range(0, 15)];
            if (op[4] && $urandom_range(0, 2) != 0) op = OP_ADD;
            if (op == OP_MULT && $urandom_range(0, 1) != 0) op = OP_MULTU;
            if (op == OP_DIV && $urandom_range(0, 1) != 0) op = OP_DIVU;
            a = rand_val();
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : rand_val();
            sh = SW'($urandom_range(0, 63));
            alu_ctrl = op; data1 = a; data2 = b; shamt = sh;
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rand spurious result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rand res", res, e);
                    check("rand zero", zero, (e == 0));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(op, a, b, sh));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                check("drain res", res, e);
            end
            @(negedge clk);
            cnt++;
        end
        check("drain empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
